// File: rtl/demux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// demux_scan_sequencer
//   Scans the enabled channels of an 8-way demux. Each enabled channel is held
//   on the select lines for a programmable number of cycles. The scan can run
//   continuously or as one single pass.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   scan request, sampled only while idle
//   stop       in   synchronous abort; beats start and dwell expiry
//   mode       in   0 = continuous, 1 = single pass (latched at start)
//   ch_mask    in   channel enables, bit i = channel i (latched at start)
//   dwell      in   cycles per channel, 0 is treated as 1 (latched at start)
//   din        in   data bit to be routed
//   s          out  demux select
//   dout       out  din gated by route_en (combinational)
//   route_en   out  registered, high while a channel is being served
//   busy       out  high while a scan is in progress
//   pass_done  out  one-cycle pulse when the highest enabled channel expires
//   cfg_err    out  one-cycle pulse for a start with an empty mask
// ---------------------------------------------------------------------------
module demux_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               din,
  output logic [2:0]         s,
  output logic               dout,
  output logic               route_en,
  output logic               busy,
  output logic               pass_done,
  output logic               cfg_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           s_q, s_d;
  logic                 route_en_q, route_en_d;
  logic                 pass_done_q, pass_done_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [7:0]           mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;

  logic [7:0]           higher_mask;
  logic [DWELL_W-1:0]   dwell_eff;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Enabled channels strictly above the current one; empty means the current
  // channel is the last of the pass.
  for (genvar gi = 0; gi < 8; gi++) begin : g_higher
    assign higher_mask[gi] = mask_q[gi] && (s_q < 3'(gi));
  end

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      route_en_q  <= 1'b0;
      pass_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      mask_q      <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      route_en_q  <= route_en_d;
      pass_done_q <= pass_done_d;
      cfg_err_q   <= cfg_err_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    route_en_d  = route_en_q;
    pass_done_d = 1'b0;
    cfg_err_d   = 1'b0;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;

    if (stop) begin
      state_d    = IDLE;
      s_d        = '0;
      route_en_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (ch_mask != 8'h00) begin
              mode_d     = mode;
              mask_d     = ch_mask;
              dwell_d    = dwell_eff;
              cnt_d      = dwell_eff;
              s_d        = lowest_set(ch_mask);
              route_en_d = 1'b1;
              state_d    = DWELL;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        DWELL: begin
          // Counter holds the cycles left on this channel, including the
          // current one, so a value of 1 means this edge ends the dwell.
          if (cnt_q <= DWELL_W'(1)) begin
            if (higher_mask != 8'h00) begin
              s_d   = lowest_set(higher_mask);
              cnt_d = dwell_q;
            end else begin
              pass_done_d = 1'b1;
              if (mode_q) begin
                state_d    = IDLE;
                s_d        = '0;
                route_en_d = 1'b0;
              end else begin
                s_d   = lowest_set(mask_q);
                cnt_d = dwell_q;
              end
            end
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          s_d        = '0;
          route_en_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    s         = s_q;
    route_en  = route_en_q;
    busy      = (state_q == DWELL);
    pass_done = pass_done_q;
    cfg_err   = cfg_err_q;
    dout      = din & route_en_q;
  end

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demux_scan_sequencer
//   Directed self-checking bench for demux_scan_sequencer. Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_demux_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       din;
  logic [2:0] s;
  logic       dout;
  logic       route_en;
  logic       busy;
  logic       pass_done;
  logic       cfg_err;

  int checks_cnt;
  int fail_cnt;

  demux_scan_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .ch_mask   (ch_mask),
    .dwell     (dwell),
    .din       (din),
    .s         (s),
    .dout      (dout),
    .route_en  (route_en),
    .busy      (busy),
    .pass_done (pass_done),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_s"}, 32'(s), 32'd0);
    check_val({tag, "_route"}, 32'(route_en), 32'd0);
    check_val({tag, "_pass"}, 32'(pass_done), 32'd0);
  endtask

  initial begin
    checks_cnt = 0;
    fail_cnt   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    mode    = 1'b0;
    ch_mask = 8'h00;
    dwell   = 8'd0;
    din     = 1'b1;

    // Reset state
    #2;
    check_idle("rst");
    check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
    check_val("rst_dout", 32'(dout), 32'd0);
    $display("txn reset s=%0d busy=%0b", s, busy);

    // A: mask FF, dwell 1, continuous; start on the first edge after release
    @(negedge clk);
    rst_n   = 1'b1;
    start   = 1'b1;
    ch_mask = 8'hFF;
    dwell   = 8'd1;
    mode    = 1'b0;
    tick();
    start = 1'b0;
    check_val("A_s0", 32'(s), 32'd0);
    check_val("A_busy0", 32'(busy), 32'd1);
    check_val("A_route0", 32'(route_en), 32'd1);
    check_val("A_pass0", 32'(pass_done), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val($sformatf("A_s%0d", k), 32'(s), 32'(k % 8));
      check_val($sformatf("A_pass%0d", k), 32'(pass_done), 32'((k % 8) == 0));
      check_val($sformatf("A_busy%0d", k), 32'(busy), 32'd1);
      $display("txn A k=%0d s=%0d pass=%0b", k, s, pass_done);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("A_stop");

    // B: mask 24, dwell 3, single pass; mask/mode edits mid-scan are ignored
    ch_mask = 8'h24;
    dwell   = 8'd3;
    mode    = 1'b1;
    din     = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    ch_mask = 8'hFF;
    mode    = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (j > 0) tick();
      check_val($sformatf("B_s%0d", j), 32'(s), (j < 3) ? 32'd2 : 32'd5);
      check_val($sformatf("B_dout%0d", j), 32'(dout), 32'd1);
      check_val($sformatf("B_busy%0d", j), 32'(busy), 32'd1);
      check_val($sformatf("B_pass%0d", j), 32'(pass_done), 32'd0);
      $display("txn B j=%0d s=%0d dout=%0b", j, s, dout);
    end
    tick();
    check_val("B_end_pass", 32'(pass_done), 32'd1);
    check_val("B_end_busy", 32'(busy), 32'd0);
    check_val("B_end_s", 32'(s), 32'd0);
    check_val("B_end_dout", 32'(dout), 32'd0);
    tick();
    check_val("B_after_pass", 32'(pass_done), 32'd0);

    // C: empty mask
    ch_mask = 8'h00;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_val("C_cfg_err", 32'(cfg_err), 32'd1);
    check_idle("C");
    tick();
    check_val("C_cfg_err_clr", 32'(cfg_err), 32'd0);
    check_val("C_busy2", 32'(busy), 32'd0);
    $display("txn C cfg_err pulse done");

    // D: mask 80, dwell 0 -> D = 1, pass every cycle, restart ignored
    ch_mask = 8'h80;
    dwell   = 8'd0;
    mode    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_val("D_s0", 32'(s), 32'd7);
    check_val("D_pass0", 32'(pass_done), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 2) begin
        ch_mask = 8'h01;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      check_val($sformatf("D_s%0d", k), 32'(s), 32'd7);
      check_val($sformatf("D_pass%0d", k), 32'(pass_done), 32'd1);
      $display("txn D k=%0d s=%0d pass=%0b", k, s, pass_done);
    end
    start = 1'b0;
    stop  = 1'b1;
    tick();
    stop = 1'b0;
    check_idle("D_stop");

    // E: mask 0F, dwell 4; stop+start on 2nd cycle of channel 3
    ch_mask = 8'h0F;
    dwell   = 8'd4;
    mode    = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check_val("E_s0", 32'(s), 32'd0);
    for (int j = 1; j <= 13; j++) begin
      tick();
      check_val($sformatf("E_s%0d", j), 32'(s), 32'(j / 4));
    end
    stop  = 1'b1;
    start = 1'b1;
    tick();
    check_idle("E_stop");
    $display("txn E stop s=%0d busy=%0b", s, busy);
    stop  = 1'b0;
    start = 1'b0;
    tick();
    check_idle("E_hold");

    // F: asynchronous reset between edges mid-scan
    ch_mask = 8'h0C;
    dwell   = 8'd2;
    din     = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_val("F_pre_s", 32'(s), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("F_rst");
    check_val("F_rst_dout", 32'(dout), 32'd0);
    #2;
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("F_restart_s", 32'(s), 32'd2);
    check_val("F_restart_busy", 32'(busy), 32'd1);
    check_val("F_restart_dout", 32'(dout), 32'd1);
    $display("txn F restart s=%0d busy=%0b", s, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
